// File: rtl/song_writer.sv
// Records a monophonic key performance into song RAM entries {note_type, note, duration, metadata}.
// A rest entry carrying the beats since the previous note start precedes each new note.
module song_writer (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        record_i,
  input  logic [1:0]  song_i,
  input  logic        beat_i,
  input  logic        key_press_i,
  input  logic        key_release_i,
  input  logic [5:0]  key_note_i,
  input  logic [2:0]  key_meta_i,
  output logic        wr_en_o,
  output logic [6:0]  wr_addr_o,
  output logic [15:0] wr_data_o,
  output logic        recording_o,
  output logic        rec_done_o,
  output logic [5:0]  entries_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GAP     = 3'd1,
    S_WR_REST = 3'd2,
    S_HELD    = 3'd3,
    S_WR_NOTE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  wr_ptr_q, wr_ptr_d;
  logic [4:0]  note_slot_q, note_slot_d;
  logic [4:0]  gap_cnt_q, gap_cnt_d;
  logic [5:0]  dur_cnt_q, dur_cnt_d;
  logic [1:0]  song_q, song_d;
  logic [5:0]  note_q, note_d;
  logic [2:0]  meta_q, meta_d;
  logic        rest_to_held_q, rest_to_held_d;
  logic        wr_en_q, wr_en_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        recording_q, recording_d;
  logic        rec_done_q, rec_done_d;
  logic [5:0]  entries_q, entries_d;

  logic [4:0]  gap_beat_s;
  logic [5:0]  need_s;
  logic [5:0]  avail_s;
  logic [5:0]  dur_wr_s;

  function automatic logic [4:0] sat_inc5(input logic [4:0] v);
    sat_inc5 = (v == 5'd31) ? 5'd31 : v + 5'd1;
  endfunction

  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    sat_inc6 = (v == 6'd63) ? 6'd63 : v + 6'd1;
  endfunction

  // a beat arriving with a press is counted into the gap before the rest is sized
  assign gap_beat_s = beat_i ? sat_inc5(gap_cnt_q) : gap_cnt_q;
  assign need_s     = (gap_beat_s != 5'd0) ? 6'd2 : 6'd1;
  assign avail_s    = 6'd32 - wr_ptr_q;

  // Next-state, counter and output-register logic
  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    note_slot_d    = note_slot_q;
    gap_cnt_d      = gap_cnt_q;
    dur_cnt_d      = dur_cnt_q;
    song_d         = song_q;
    note_d         = note_q;
    meta_d         = meta_q;
    rest_to_held_d = rest_to_held_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = 7'd0;
    wr_data_d      = 16'd0;
    dur_wr_s       = 6'd0;

    case (state_q)
      S_IDLE: begin
        if (record_i) begin
          state_d   = S_GAP;
          wr_ptr_d  = 6'd0;
          gap_cnt_d = 5'd0;
          dur_cnt_d = 6'd0;
          song_d    = song_i;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (!record_i) begin
          state_d = S_DONE;
        end else if (key_press_i) begin
          note_d    = key_note_i;
          meta_d    = key_meta_i;
          gap_cnt_d = gap_beat_s;
          if (need_s > avail_s) begin
            state_d = S_DONE;
          end else if (gap_beat_s != 5'd0) begin
            state_d        = S_WR_REST;
            rest_to_held_d = 1'b1;
          end else begin
            state_d     = S_HELD;
            note_slot_d = wr_ptr_q[4:0];
            wr_ptr_d    = wr_ptr_q + 6'd1;
            dur_cnt_d   = 6'd0;
          end
        end else if (beat_i && (gap_cnt_q >= 5'd30)) begin
          // gap would hit the rest field limit: flush a full-length rest and keep waiting
          if (wr_ptr_q == 6'd32) begin
            state_d = S_DONE;
          end else begin
            state_d        = S_WR_REST;
            rest_to_held_d = 1'b0;
            gap_cnt_d      = 5'd31;
          end
        end else begin
          gap_cnt_d = gap_beat_s;
        end
      end
      S_WR_REST: begin
        gap_cnt_d = 5'd0;
        if (rest_to_held_q) begin
          state_d     = S_HELD;
          note_slot_d = wr_ptr_q[4:0] + 5'd1;
          wr_ptr_d    = wr_ptr_q + 6'd2;
          dur_cnt_d   = 6'd0;
        end else begin
          state_d  = S_GAP;
          wr_ptr_d = wr_ptr_q + 6'd1;
        end
      end
      S_HELD: begin
        if (beat_i) begin
          dur_cnt_d = sat_inc6(dur_cnt_q);
          gap_cnt_d = sat_inc5(gap_cnt_q);
        end else begin
          dur_cnt_d = dur_cnt_q;
        end
        if (key_release_i || !record_i) begin
          state_d = S_WR_NOTE;
        end else begin
          state_d = S_HELD;
        end
      end
      S_WR_NOTE: begin
        if (record_i) begin
          state_d = S_GAP;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (record_i) begin
          state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // write strobes are registered, so they are decoded from the state being entered
    case (state_d)
      S_WR_REST: begin
        wr_en_d   = 1'b1;
        wr_addr_d = {song_q, wr_ptr_q[4:0]};
        wr_data_d = {1'b1, 1'b0, gap_cnt_d, 6'd0, 3'd0};
      end
      S_WR_NOTE: begin
        dur_wr_s  = (dur_cnt_d == 6'd0) ? 6'd1 : dur_cnt_d;
        wr_en_d   = 1'b1;
        wr_addr_d = {song_q, note_slot_q};
        wr_data_d = {1'b0, note_q, dur_wr_s, meta_q};
      end
      default: begin
        wr_en_d = 1'b0;
      end
    endcase

    recording_d = (state_d == S_GAP) || (state_d == S_HELD) ||
                  (state_d == S_WR_REST) || (state_d == S_WR_NOTE);
    rec_done_d  = (state_d == S_DONE);
    entries_d   = wr_ptr_d;
  end

  // State, counter and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= 6'd0;
      note_slot_q    <= 5'd0;
      gap_cnt_q      <= 5'd0;
      dur_cnt_q      <= 6'd0;
      song_q         <= 2'd0;
      note_q         <= 6'd0;
      meta_q         <= 3'd0;
      rest_to_held_q <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= 7'd0;
      wr_data_q      <= 16'd0;
      recording_q    <= 1'b0;
      rec_done_q     <= 1'b0;
      entries_q      <= 6'd0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      note_slot_q    <= note_slot_d;
      gap_cnt_q      <= gap_cnt_d;
      dur_cnt_q      <= dur_cnt_d;
      song_q         <= song_d;
      note_q         <= note_d;
      meta_q         <= meta_d;
      rest_to_held_q <= rest_to_held_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      recording_q    <= recording_d;
      rec_done_q     <= rec_done_d;
      entries_q      <= entries_d;
    end
  end

  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign recording_o = recording_q;
  assign rec_done_o  = rec_done_q;
  assign entries_o   = entries_q;

endmodule

// File: tb/tb_song_writer.sv
// Bench for song_writer: directed scenarios with constant expectations plus random takes
// checked against an event-level model of the recording rules.
module tb_song_writer;

  logic        clk_i = 1'b0;
  logic        reset_i, record_i, beat_i, key_press_i, key_release_i;
  logic [1:0]  song_i;
  logic [5:0]  key_note_i;
  logic [2:0]  key_meta_i;
  logic        wr_en_o;
  logic [6:0]  wr_addr_o;
  logic [15:0] wr_data_o;
  logic        recording_o, rec_done_o;
  logic [5:0]  entries_o;

  int total = 0;
  int bad   = 0;

  song_writer dut (
    .clk_i(clk_i), .reset_i(reset_i), .record_i(record_i), .song_i(song_i),
    .beat_i(beat_i), .key_press_i(key_press_i), .key_release_i(key_release_i),
    .key_note_i(key_note_i), .key_meta_i(key_meta_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .recording_o(recording_o), .rec_done_o(rec_done_o), .entries_o(entries_o)
  );

  always #5 clk_i = ~clk_i;

  // reference model: 0 idle, 1 waiting between notes, 2 note held, 3 take finished
  int          m_mode, m_gap, m_dur, m_ptr, m_slot;
  logic [1:0]  m_song;
  logic [5:0]  m_note;
  logic [2:0]  m_meta;
  logic        m_wr;
  logic [6:0]  m_addr;
  logic [15:0] m_data;

  logic        last_wr;
  logic [6:0]  last_addr;
  logic [15:0] last_data;
  logic [6:0]  obs_addr[$];
  logic [15:0] obs_data[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_gap = 0; m_dur = 0; m_ptr = 0; m_slot = 0;
    m_song = 2'd0; m_note = 6'd0; m_meta = 3'd0; m_wr = 1'b0;
  endtask

  task automatic emit(input int slot, input logic [15:0] data);
    m_wr   = 1'b1;
    m_addr = 7'(m_song * 32 + slot);
    m_data = data;
  endtask

  task automatic model_step(input logic b, input logic p, input logic r, input logic rec,
                            input logic [1:0] sg, input logic [5:0] n, input logic [2:0] mt);
    int g;
    m_wr = 1'b0;
    case (m_mode)
      0: if (rec) begin m_mode = 1; m_ptr = 0; m_gap = 0; m_dur = 0; m_song = sg; end
      1: begin
        if (!rec) m_mode = 3;
        else if (p) begin
          g = (m_gap + int'(b) > 31) ? 31 : m_gap + int'(b);
          m_note = n; m_meta = mt;
          if (((g != 0) ? 2 : 1) > 32 - m_ptr) m_mode = 3;
          else begin
            if (g != 0) begin emit(m_ptr, 16'h8000 | 16'(g << 9)); m_ptr++; end
            m_slot = m_ptr; m_ptr++; m_dur = 0; m_gap = 0; m_mode = 2;
          end
        end else if (b) begin
          g = (m_gap + 1 > 31) ? 31 : m_gap + 1;
          if (g == 31) begin
            if (m_ptr == 32) m_mode = 3;
            else begin emit(m_ptr, 16'hBE00); m_ptr++; m_gap = 0; end
          end else m_gap = g;
        end
      end
      2: begin
        if (b) begin
          m_dur = (m_dur == 63) ? 63 : m_dur + 1;
          m_gap = (m_gap == 31) ? 31 : m_gap + 1;
        end
        if (r || !rec) begin
          emit(m_slot, 16'((int'(m_note) << 9) | (((m_dur == 0) ? 1 : m_dur) << 3) | int'(m_meta)));
          m_mode = rec ? 1 : 3;
        end
      end
      default: if (!rec) m_mode = 0;
    endcase
  endtask

  // one event cycle followed by one quiet cycle; writes and slot count checked against the model
  task automatic pair(input logic b, input logic p, input logic r,
                      input logic [5:0] n, input logic [2:0] mt, input string tag);
    beat_i = b; key_press_i = p; key_release_i = r; key_note_i = n; key_meta_i = mt;
    model_step(b, p, r, record_i, song_i, n, mt);
    @(posedge clk_i); #1;
    beat_i = 1'b0; key_press_i = 1'b0; key_release_i = 1'b0;
    last_wr = wr_en_o; last_addr = wr_addr_o; last_data = wr_data_o;
    if (wr_en_o) begin obs_addr.push_back(wr_addr_o); obs_data.push_back(wr_data_o); end
    chk($sformatf("%s wr_en", tag), wr_en_o, m_wr);
    if (m_wr) begin
      chk($sformatf("%s wr_addr", tag), wr_addr_o, m_addr);
      chk($sformatf("%s wr_data", tag), wr_data_o, m_data);
    end
    model_step(1'b0, 1'b0, 1'b0, record_i, song_i, 6'd0, 3'd0);
    @(posedge clk_i); #1;
    chk($sformatf("%s quiet wr_en", tag), wr_en_o, 32'd0);
    chk($sformatf("%s entries", tag), entries_o, 32'(m_ptr));
  endtask

  task automatic end_take(input string tag);
    record_i = 1'b0;
    for (int i = 0; i < 3; i++) pair(1'b0, 1'b0, 1'b0, 6'd0, 3'd0, tag);
    chk($sformatf("%s idle recording", tag), recording_o, 32'd0);
    chk($sformatf("%s idle rec_done", tag), rec_done_o, 32'd0);
  endtask

  initial begin
    reset_i = 1'b0; record_i = 1'b0; song_i = 2'd0; beat_i = 1'b0;
    key_press_i = 1'b0; key_release_i = 1'b0; key_note_i = 6'd0; key_meta_i = 3'd0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst wr_en", wr_en_o, 32'd0);
    chk("rst wr_addr", wr_addr_o, 32'd0);
    chk("rst wr_data", wr_data_o, 32'd0);
    chk("rst entries", entries_o, 32'd0);
    chk("rst recording", recording_o, 32'd0);
    chk("rst rec_done", rec_done_o, 32'd0);
    reset_i = 1'b1;

    // basic rest + note
    song_i = 2'd2; record_i = 1'b1;
    pair(1'b0, 1'b0, 1'b0, 6'd0, 3'd0, "t1 start");
    chk("t1 recording", recording_o, 32'd1);
    repeat (3) pair(1'b1, 1'b0, 1'b0, 6'd0, 3'd0, "t1 gap");
    pair(1'b0, 1'b1, 1'b0, 6'd12, 3'd5, "t1 press");
    chk("t1 rest addr", last_addr, 32'd64);
    chk("t1 rest data", last_data, 32'h8600);
    repeat (4) pair(1'b1, 1'b0, 1'b0, 6'd0, 3'd0, "t1 hold");
    pair(1'b0, 1'b0, 1'b1, 6'd0, 3'd0, "t1 release");
    chk("t1 note addr", last_addr, 32'd65);
    chk("t1 note data", last_data, 32'h1825);
    chk("t1 entries", entries_o, 32'd2);
    end_take("t1 end");

    // zero gap press, zero-length note
    song_i = 2'd1; record_i = 1'b1;
    pair(1'b0, 1'b0, 1'b0, 6'd0, 3'd0, "t2 start");
    pair(1'b0, 1'b1, 1'b0, 6'd7, 3'd2, "t2 press");
    chk("t2 no rest", last_wr, 32'd0);
    pair(1'b0, 1'b0, 1'b1, 6'd0, 3'd0, "t2 release");
    chk("t2 note addr", last_addr, 32'd32);
    chk("t2 note data", last_data, 32'h0E0A);
    end_take("t2 end");

    // long idle gap, then fill the song
    song_i = 2'd0; record_i = 1'b1;
    pair(1'b0, 1'b0, 1'b0, 6'd0, 3'd0, "t3 start");
    obs_addr.delete(); obs_data.delete();
    repeat (70) pair(1'b1, 1'b0, 1'b0, 6'd0, 3'd0, "t3 gap");
    chk("t3 rest count", obs_addr.size(), 32'd2);
    chk("t3 rest0 addr", obs_addr[0], 32'd0);
    chk("t3 rest0 data", obs_data[0], 32'hBE00);
    chk("t3 rest1 addr", obs_addr[1], 32'd1);
    chk("t3 rest1 data", obs_data[1], 32'hBE00);
    pair(1'b0, 1'b1, 1'b0, 6'd3, 3'd0, "t3 press");
    chk("t3 residual rest addr", last_addr, 32'd2);
    chk("t3 residual rest data", last_data, 32'h9000);
    pair(1'b0, 1'b0, 1'b1, 6'd0, 3'd0, "t3 release");
    for (int i = 0; i < 27; i++) begin
      pair(1'b0, 1'b1, 1'b0, 6'(i), 3'(i), "t4 fill press");
      pair(1'b0, 1'b0, 1'b1, 6'd0, 3'd0, "t4 fill release");
    end
    chk("t4 entries 31", entries_o, 32'd31);
    pair(1'b1, 1'b0, 1'b0, 6'd0, 3'd0, "t4 beat");
    pair(1'b0, 1'b1, 1'b0, 6'd9, 3'd1, "t4 press full");
    chk("t4 no write", last_wr, 32'd0);
    chk("t4 rec_done", rec_done_o, 32'd1);
    chk("t4 recording", recording_o, 32'd0);
    chk("t4 entries", entries_o, 32'd31);
    end_take("t4 end");

    // long hold saturates duration and gap; second press ignored
    song_i = 2'd3; record_i = 1'b1;
    pair(1'b0, 1'b0, 1'b0, 6'd0, 3'd0, "t5 start");
    pair(1'b0, 1'b1, 1'b0, 6'd40, 3'd1, "t5 press");
    repeat (40) pair(1'b1, 1'b0, 1'b0, 6'd0, 3'd0, "t5 hold");
    pair(1'b0, 1'b1, 1'b0, 6'd5, 3'd6, "t5 second press");
    chk("t5 second press no write", last_wr, 32'd0);
    chk("t5 second press entries", entries_o, 32'd1);
    repeat (40) pair(1'b1, 1'b0, 1'b0, 6'd0, 3'd0, "t5 hold");
    pair(1'b0, 1'b0, 1'b1, 6'd0, 3'd0, "t5 release");
    chk("t5 note addr", last_addr, 32'd96);
    chk("t5 note data", last_data, 32'h51F9);
    pair(1'b0, 1'b1, 1'b0, 6'd2, 3'd3, "t5 next press");
    chk("t5 sat rest addr", last_addr, 32'd97);
    chk("t5 sat rest data", last_data, 32'hBE00);

    // reset while a note is held
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    chk("t6 wr_en", wr_en_o, 32'd0);
    chk("t6 entries", entries_o, 32'd0);
    chk("t6 recording", recording_o, 32'd0);
    chk("t6 rec_done", rec_done_o, 32'd0);
    model_reset();
    reset_i = 1'b1; record_i = 1'b0;
    pair(1'b0, 1'b0, 1'b1, 6'd0, 3'd0, "t6 stray release");
    chk("t6 reserved slot unwritten", last_wr, 32'd0);

    // random takes against the model
    for (int take = 0; take < 4; take++) begin
      song_i = 2'($urandom_range(0, 3));
      record_i = 1'b1;
      pair(1'b0, 1'b0, 1'b0, 6'd0, 3'd0, "rnd start");
      for (int s = 0; s < 250; s++) begin
        int r;
        logic [5:0] n;
        logic [2:0] mt;
        r  = $urandom_range(0, 99);
        n  = 6'($urandom);
        mt = 3'($urandom);
        if (r < 55)      pair(1'b1, 1'b0, 1'b0, n, mt, "rnd beat");
        else if (r < 65) pair(1'b0, 1'b1, 1'b0, n, mt, "rnd press");
        else if (r < 75) pair(1'b0, 1'b0, 1'b1, n, mt, "rnd release");
        else if (r < 82) pair(1'b1, 1'b1, 1'b0, n, mt, "rnd beat+press");
        else if (r < 89) pair(1'b1, 1'b0, 1'b1, n, mt, "rnd beat+release");
        else if (r < 93) pair(1'b0, 1'b1, 1'b1, n, mt, "rnd press+release");
        else             pair(1'b0, 1'b0, 1'b0, n, mt, "rnd idle");
      end
      end_take("rnd end");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/song_writer.md
# song_writer

Records a monophonic performance into a song RAM in the exact 16-bit entry format the song playback path consumes: {note_type, note[5:0], duration[5:0], metadata[2:0]}. Key press/release events from the user-input front end are timed in 48 Hz `beat` ticks; each new note start is preceded by a rest entry carrying the beats elapsed since the previous note start, so the greedy playback reader reproduces the original timing. Sits between the keypad debouncer and the write port of the 128×16 song RAM (4 songs × 32 entries).

## Interface
- No parameters; entry format and depth are fixed (32 entries per song, 4 songs).
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low (reset when `reset == 0`).
- `record` in 1: level; rising edge starts a take, low ends it.
- `song` in 2: target song slot; sampled on the `IDLE` → `GAP` transition.
- `beat` in 1: one-cycle 48 Hz tick.
- `key_press` in 1: one-cycle pulse, key went down.
- `key_release` in 1: one-cycle pulse, key went up.
- `key_note` in 6: note code, sampled with `key_press`.
- `key_meta` in 3: metadata, sampled with `key_press`.
- `wr_en` out 1: RAM write strobe, one cycle per entry.
- `wr_addr` out 7: {song, slot[4:0]}.
- `wr_data` out 16: {note_type, note, duration, metadata}.
- `recording` out 1: high in `GAP`, `HELD`, `WR_REST`, `WR_NOTE`.
- `rec_done` out 1: high in `DONE`.
- `entries` out 6: slots consumed in this take, 0..32.

## Operation
- States: `IDLE`, `GAP`, `WR_REST`, `HELD`, `WR_NOTE`, `DONE`.
- Registers: `wr_ptr` (6 bits, 0..32), `note_slot` (5), `gap_cnt` (5), `dur_cnt` (6), latched `song_r`, `note_r`, `meta_r`.
- `IDLE`: `record` high → `GAP`. Clear `wr_ptr`, `gap_cnt`, `dur_cnt`; latch `song`.
- `GAP`:
  - `beat` increments `gap_cnt`.
  - When `gap_cnt` would reach 31: write a saturated rest entry (note field 31), set `gap_cnt` to 0, and stay in `GAP`. This goes through `WR_REST` with a return to `GAP`.
  - `key_press`: latch note and meta.
    - Required slots are 2 if `gap_cnt != 0`, else 1. Slots available are `32 - wr_ptr`.
    - Insufficient slots → `DONE` with no write.
    - Otherwise, `gap_cnt != 0` → `WR_REST` (return to `HELD`); `gap_cnt == 0` → `HELD`.
  - `record` low → `DONE`. Pending gap beats are discarded.
- `WR_REST`:
  - One cycle. `wr_en = 1`, `wr_addr = {song_r, wr_ptr[4:0]}`, `wr_data = {1'b1, {1'b0, gap_cnt}, 6'd0, 3'd0}`.
  - `wr_ptr++`, clear `gap_cnt`.
  - A saturation rest needing a slot when `wr_ptr == 32` → `DONE` instead.
- Entering `HELD`: `note_slot = wr_ptr[4:0]`, `wr_ptr++` (slot reserved), `dur_cnt = 0`.
- `HELD`:
  - `beat` increments both `dur_cnt` (saturates at 63) and `gap_cnt` (saturates at 31; gap is measured note start to note start).
  - `key_press` is ignored (monophonic).
  - `key_release` or `record` low → `WR_NOTE`.
- `WR_NOTE`:
  - One cycle. `wr_en = 1`, `wr_addr = {song_r, note_slot}`, `wr_data = {1'b0, note_r, dur_cnt, meta_r}`.
  - Duration 0 is written as 1.
  - Next state: `GAP` if `record` is high, else `DONE`.
- `DONE`: no writes; stay until `record` is low, then → `IDLE`.
- `key_release` outside `HELD` is ignored.
- `entries = wr_ptr`.

## Timing
- Reset (`reset == 0` at a `clk` edge) → `IDLE`; all outputs 0 and all counters 0 on the following cycle. This applies mid-take: any reserved slot is abandoned unwritten.
- `key_press` in `GAP` at cycle t, with nonzero gap: rest write asserted at t+1, `HELD` at t+2. With zero gap: `HELD` at t+1.
- `key_release` at cycle t: note write asserted at t+1.
- `beat` coincident with `key_press` counts into `gap_cnt` before the rest is written.
- `beat` coincident with `key_release` counts into `dur_cnt`.
- `key_press` and `key_release` in the same cycle while in `GAP`: the press wins and the release is dropped.
- `wr_en` is never high two consecutive cycles except rest → note-reserve sequences, which do not write. At most one write per cycle.
- `wr_addr`/`wr_data` are valid only while `wr_en` is high; otherwise they are held at 0.

## Test plan
- `song` = 2, `record` high, 3 beats, press note 12 meta 5, 4 beats, release. Required: write addr 64 data {1,000011,000000,000} → addr 65 data {0,001100,000100,101}; `entries` = 2.
- Press with 0 gap immediately after record start. Required: single note write at addr {song,0}, no rest entry.
- 70 beats idle in `GAP`. Required: rest writes of 31, 31 at slots 0,1, then `gap_cnt` = 8 and no third write.
- Fill to `wr_ptr` = 31, then press with a nonzero gap. Required: `DONE`, no write, `rec_done` = 1, `entries` = 31.
- Hold a note for 80 beats, then release. Required: duration field 63. Second press during the hold: no effect.
- `reset` low while in `HELD`. Required: next cycle `IDLE`, `wr_en` = 0, `entries` = 0, reserved slot never written.
